// File: rtl/vr_width_packer.sv
// Packs RATIO narrow WIDTH-bit beats into one WIDTH*RATIO-bit word on a valid/ready output.
// Optional macro VR_PACK_LAST_EN adds in_last/out_keep/out_last for early-closed partial words.
module vr_width_packer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RATIO = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WIDTH*RATIO-1:0] out_data,
    input  logic                   out_ready
`ifdef VR_PACK_LAST_EN
    ,
    input  logic                   in_last,
    output logic [RATIO-1:0]       out_keep,
    output logic                   out_last
`endif
);

    localparam int unsigned OW = WIDTH * RATIO;
    localparam int unsigned CW = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic [OW-1:0]   r_data;
    logic [OW-1:0]   w_data_nxt;
    logic            w_accept;
    logic            w_close;
    logic            w_last_beat;

`ifdef VR_PACK_LAST_EN
    assign w_last_beat = in_last;
`else
    assign w_last_beat = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a closing beat always lands in FULL, even when it rides a drain
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept && w_close) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && out_ready) begin
            w_state_nxt = ST_FILL;
        end
    end

    // Handshake outputs; in FULL a beat may only enter while the word drains
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        if (r_state == ST_FULL) begin
            in_ready  = out_ready;
            out_valid = 1'b1;
        end
    end

    assign w_accept = in_valid && in_ready;
    assign w_close  = (r_count == CW'(RATIO - 1)) || w_last_beat;

    // Lane write; a last beat also zeroes the lanes above it
    always_comb begin
        w_count_nxt = r_count;
        w_data_nxt  = r_data;
        if (w_accept) begin
            w_count_nxt = w_close ? '0 : r_count + CW'(1);
            for (int k = 0; k < int'(RATIO); k++) begin
                if (k == int'(r_count)) begin
                    w_data_nxt[k*WIDTH +: WIDTH] = in_data;
                end else if (w_last_beat && (k > int'(r_count))) begin
                    w_data_nxt[k*WIDTH +: WIDTH] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_data  <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign out_data = r_data;

`ifdef VR_PACK_LAST_EN
    logic [RATIO-1:0] r_keep;
    logic [RATIO-1:0] w_keep_nxt;
    logic             r_last;

    always_comb begin
        w_keep_nxt = '0;
        for (int k = 0; k < int'(RATIO); k++) begin
            w_keep_nxt[k] = (k <= int'(r_count));
        end
    end

    // Keep/last captured only when a word closes, so they stay stable while pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_keep <= '0;
            r_last <= 1'b0;
        end else if (w_accept && w_close) begin
            r_keep <= w_keep_nxt;
            r_last <= in_last;
        end
    end

    assign out_keep = r_keep;
    assign out_last = r_last;
`endif

endmodule

// File: tb/tb_vr_width_packer.sv
// Self-checking bench for vr_width_packer: vector table, hand sequences and a scoreboard.
module tb_vr_width_packer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned RATIO = 4;
    localparam int unsigned OW    = WIDTH * RATIO;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_ready;
    logic              out_valid;
    logic [OW-1:0]     out_data;
    logic              out_ready;
    logic              drv_last;
`ifdef VR_PACK_LAST_EN
    logic [RATIO-1:0]  out_keep;
    logic              out_last;
`endif

    vr_width_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef VR_PACK_LAST_EN
        ,
        .in_last   (drv_last),
        .out_keep  (out_keep),
        .out_last  (out_last)
`endif
    );

    typedef struct {
        logic [OW-1:0]    data;
        logic [RATIO-1:0] keep;
        logic             last;
    } word_t;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp;
    } vec_t;

    word_t       sb[$];
    word_t       e;
    word_t       w;
    logic [7:0]  m_lane[RATIO];
    int          m_cnt = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    int          checks = 0;
    int          failures = 0;
    int          words_seen = 0;
    int          cyc = 0;
    bit          rand_en = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Monitor: reference packing model, scoreboard pop and hold-stability check
    always @(negedge clk) begin
        if (!rst_n) begin
            m_cnt = 0;
            sb.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                words_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", out_data, e.data);
`ifdef VR_PACK_LAST_EN
                    check("sb_keep", 32'(out_keep), 32'(e.keep));
                    check("sb_last", 32'(out_last), 32'(e.last));
`endif
                end
            end
            if (in_valid && in_ready) begin
                m_lane[m_cnt] = in_data;
                if ((m_cnt == int'(RATIO) - 1) || drv_last) begin
                    w.data = '0;
                    for (int k = 0; k <= m_cnt; k++) w.data[k*WIDTH +: WIDTH] = m_lane[k];
                    w.keep = RATIO'((1 << (m_cnt + 1)) - 1);
                    w.last = drv_last;
                    sb.push_back(w);
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Present one beat and hold it until accepted (bounded)
    task automatic beat(input logic [7:0] d, input logic last = 1'b0);
        int n = 0;
        bit acc = 0;
        in_valid = 1'b1;
        in_data  = d;
        drv_last = last;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (rand_en) out_ready = 1'($urandom_range(0, 1));
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: got no accept expected accept of 0x%0h", d);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        drv_last = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[4];
    int   w0;
    int   c0;

    initial begin
        vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
        vecs[1] = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 32'h00FF5AA5};
        vecs[2] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};
        vecs[3] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        drv_last = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset with two lanes filled
        beat(8'hC1);
        beat(8'hC2);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table: first entry is the clean word after reset
        for (int i = 0; i < 4; i++) begin
            beat(vecs[i].b0);
            beat(vecs[i].b1);
            beat(vecs[i].b2);
            beat(vecs[i].b3);
            idle();
            @(negedge clk);
            check("vec_valid", 32'(out_valid), 32'd1);
            check("vec_data", out_data, vecs[i].exp);
            @(posedge clk);
            #1;
            @(negedge clk);
            check("vec_drained", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        wait_drain();

        // Backpressure with a waiting beat
        out_ready = 1'b0;
        beat(8'h11);
        beat(8'h22);
        beat(8'h33);
        beat(8'h44);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", out_data, 32'h44332211);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        check("bp_after_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        beat(8'h66);
        beat(8'h77);
        beat(8'h88);
        idle();
        @(negedge clk);
        check("bp_next_word", out_data, 32'h88776655);
        @(posedge clk);
        #1;
        wait_drain();

        // Streaming at one beat per cycle
        w0 = words_seen;
        c0 = cyc;
        for (int i = 0; i < 16; i++) beat(8'(8'h10 + i));
        check("stream_cycles", 32'(cyc - c0), 32'd16);
        idle();
        wait_drain();
        check("stream_words", 32'(words_seen - w0), 32'd4);

        // Random valid/ready traffic
        w0 = words_seen;
        rand_en = 1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                out_ready = 1'($urandom_range(0, 1));
            end
            beat(8'($urandom));
        end
        rand_en = 0;
        out_ready = 1'b1;
        idle();
        wait_drain();
        check("random_words", 32'(words_seen - w0), 32'd250);

`ifdef VR_PACK_LAST_EN
        // Early close by in_last
        beat(8'hAA);
        beat(8'hBB, 1'b1);
        idle();
        @(negedge clk);
        check("last_data", out_data, 32'h0000BBAA);
        check("last_keep", 32'(out_keep), 32'h3);
        check("last_flag", 32'(out_last), 32'd1);
        @(posedge clk);
        #1;
        wait_drain();
        // in_last on the final lane, then a last beat on lane 0 riding a drain
        beat(8'h01);
        beat(8'h02);
        beat(8'h03);
        beat(8'h04, 1'b1);
        out_ready = 1'b0;
        beat(8'h05);
        beat(8'h06);
        beat(8'h07);
        beat(8'h08);
        out_ready = 1'b1;
        beat(8'h99, 1'b1);
        idle();
        @(negedge clk);
        check("lane0_last_full", 32'(out_valid), 32'd1);
        check("lane0_last_keep", 32'(out_keep), 32'h1);
        @(posedge clk);
        #1;
        wait_drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
